// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control sequencer.
//   - state encoding (state_t); the low three bits double as the Step output
//   - opcode constants and the legal-opcode list
//   - IR field bit positions and the latched-field record
// The MUL/DIV opcodes only become legal when CTRL_MULDIV_EN is defined
// (see ctrl_decode).
package ctrl_pkg;

  // IDLE and FAULT both report Step=0; Fault distinguishes them.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_FAULT = 4'd8
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_SHRA = 5'h08;
  localparam logic [4:0] OP_SHL  = 5'h09;
  localparam logic [4:0] OP_ROR  = 5'h0A;
  localparam logic [4:0] OP_ROL  = 5'h0B;
  localparam logic [4:0] OP_NEG  = 5'h0C;
  localparam logic [4:0] OP_NOT  = 5'h0D;
  localparam logic [4:0] OP_MUL  = 5'h0E;
  localparam logic [4:0] OP_DIV  = 5'h0F;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned RC_LSB  = 15;

  typedef struct packed {
    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
  } fields_t;

  // Single-cycle ALU operations: always legal.
  function automatic logic op_is_alu(input logic [4:0] op);
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_NEG, OP_NOT: op_is_alu = 1'b1;
      default:                        op_is_alu = 1'b0;
    endcase
  endfunction

  // Two-result operations that need the LO/HI writeback pair.
  function automatic logic op_is_muldiv(input logic [4:0] op);
    op_is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: handshake inputs and datapath strobes of the
// control sequencer.
//   master: the sequencer (takes Run/IR/Mem_ready, drives everything else)
//   slave : the datapath / environment side
//   Run, IR, Mem_ready        : start request, instruction word, memory valid
//   PCout..HIin               : one-bit datapath strobes
//   Rout, Rin                 : one-hot register drive / load selects
//   AluOp                     : ALU operation code
//   Busy, Done, Fault, Step   : status, Step is the encoded current state
//   InstrCount                : completed-instruction counter
interface control_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
);
  logic                  Run;
  logic [DATA_WIDTH-1:0] IR;
  logic                  Mem_ready;

  logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin;
  logic Read, MDRin, MDRout, IRin, Yin, LOin, HIin;

  logic [NUM_REGS-1:0] Rout;
  logic [NUM_REGS-1:0] Rin;
  logic [4:0]          AluOp;

  logic        Busy;
  logic        Done;
  logic        Fault;
  logic [2:0]  Step;
  logic [15:0] InstrCount;

  modport master (
    input  Run, IR, Mem_ready,
    output PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
           Read, MDRin, MDRout, IRin, Yin, LOin, HIin,
           Rout, Rin, AluOp, Busy, Done, Fault, Step, InstrCount
  );

  modport slave (
    output Run, IR, Mem_ready,
    input  PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
           Read, MDRin, MDRout, IRin, Yin, LOin, HIin,
           Rout, Rin, AluOp, Busy, Done, Fault, Step, InstrCount
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: IR field extraction and instruction legality check.
//   ir        : current instruction register contents
//   fields_q  : fields latched by the sequencer (checked for legality)
//   fields_ir : fields extracted from ir (for the sequencer to latch)
//   illegal   : latched opcode unknown, or a register index >= NUM_REGS
//   muldiv    : latched opcode takes the LO/HI two-step writeback
// Macro CTRL_MULDIV_EN: when defined, MUL/DIV are legal; otherwise they
// are reported illegal and muldiv is tied low.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic [DATA_WIDTH-1:0] ir,
  input  fields_t               fields_q,
  output fields_t               fields_ir,
  output logic                  illegal,
  output logic                  muldiv
);

  // Only the field bits matter; fold the rest away.
  logic unused_ir_parity;
  assign unused_ir_parity = ^ir;

  always_comb begin
    fields_ir.opcode = ir[OPC_MSB:OPC_LSB];
    fields_ir.ra     = ir[RA_MSB:RA_LSB];
    fields_ir.rb     = ir[RB_MSB:RB_LSB];
    fields_ir.rc     = ir[RC_MSB:RC_LSB];
  end

  always_comb begin
`ifdef CTRL_MULDIV_EN
    muldiv = op_is_muldiv(fields_q.opcode);
`else
    muldiv = 1'b0;
`endif
    illegal = !(op_is_alu(fields_q.opcode) || muldiv)
           || (32'(fields_q.ra) >= NUM_REGS)
           || (32'(fields_q.rb) >= NUM_REGS)
           || (32'(fields_q.rc) >= NUM_REGS);
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction control unit.
//   Clock : sole clock, rising edge
//   Clear : asynchronous active-low reset
//   bus   : control_sequencer_if.master (Run/IR/Mem_ready in; strobes,
//           register selects, AluOp, status and InstrCount out)
// States IDLE, T0..T6, FAULT. T1 stalls on Mem_ready with a WAIT_MAX
// timeout; T3 faults on an illegal latched instruction. Strobes depend
// only on registered state, the stall counter and latched fields.
// Macro CTRL_MULDIV_EN enables the MUL/DIV T5(LO)/T6(HI) writeback.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned WAIT_MAX   = 15
) (
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master bus
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [15:0]      icount_q;
  fields_t          fld_q, fld_ir;
  logic             illegal, muldiv;
  logic             last_step;

  ctrl_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_decode (
    .ir        (bus.IR),
    .fields_q  (fld_q),
    .fields_ir (fld_ir),
    .illegal   (illegal),
    .muldiv    (muldiv)
  );

  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
    reg_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) reg_sel[i] = 1'b1;
    end
  endfunction

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= ST_IDLE;
      stall_q  <= '0;
      icount_q <= '0;
      fld_q    <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      if (last_step) icount_q <= icount_q + 16'd1;
      // T2 always lasts one cycle, so this is the edge leaving T2.
      if (state_q == ST_T2) fld_q <= fld_ir;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    last_step = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.Run) state_d = ST_T0;
      ST_T0: begin
        state_d = ST_T1;
        stall_d = '0;
      end
      ST_T1: begin
        if (bus.Mem_ready) begin
          state_d = ST_T2;
          stall_d = '0;
        end else if (stall_q == CNT_W'(WAIT_MAX - 1)) begin
          // This would be the WAIT_MAX-th cycle without data.
          state_d = ST_FAULT;
          stall_d = '0;
        end else begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      ST_T2: state_d = ST_T3;
      ST_T3: state_d = illegal ? ST_FAULT : ST_T4;
      ST_T4: state_d = ST_T5;
      ST_T5: begin
        if (muldiv) begin
          state_d = ST_T6;
        end else begin
          last_step = 1'b1;
          state_d   = bus.Run ? ST_T0 : ST_IDLE;
        end
      end
      ST_T6: begin
        last_step = 1'b1;
        state_d   = bus.Run ? ST_T0 : ST_IDLE;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.PCout  = 1'b0;
    bus.MARin  = 1'b0;
    bus.IncPC  = 1'b0;
    bus.Zin    = 1'b0;
    bus.ZLOout = 1'b0;
    bus.ZHIout = 1'b0;
    bus.PCin   = 1'b0;
    bus.Read   = 1'b0;
    bus.MDRin  = 1'b0;
    bus.MDRout = 1'b0;
    bus.IRin   = 1'b0;
    bus.Yin    = 1'b0;
    bus.LOin   = 1'b0;
    bus.HIin   = 1'b0;
    bus.Rout   = '0;
    bus.Rin    = '0;
    bus.AluOp  = '0;
    unique case (state_q)
      ST_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      ST_T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        // Stall count is zero only in the first T1 cycle: PC written once.
        if (stall_q == '0) begin
          bus.ZLOout = 1'b1;
          bus.PCin   = 1'b1;
        end
      end
      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      ST_T3: begin
        if (!illegal) begin
          bus.Rout = reg_sel(fld_q.rb);
          bus.Yin  = 1'b1;
        end
      end
      ST_T4: begin
        bus.Rout  = reg_sel(fld_q.rc);
        bus.Zin   = 1'b1;
        bus.AluOp = fld_q.opcode;
      end
      ST_T5: begin
        bus.ZLOout = 1'b1;
        if (muldiv) bus.LOin = 1'b1;
        else        bus.Rin  = reg_sel(fld_q.ra);
      end
      ST_T6: begin
        bus.ZHIout = 1'b1;
        bus.HIin   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Busy       = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign bus.Fault      = (state_q == ST_FAULT);
  assign bus.Done       = last_step;
  assign bus.Step       = 3'(state_q);
  assign bus.InstrCount = icount_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer.
// A 16-register instance carries most scenarios; an 8-register instance
// covers the out-of-range register fault. Expectations for MUL depend on
// whether CTRL_MULDIV_EN is defined for the build.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Clear;
  always #5 Clock = ~Clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Strobe vector bit positions, see strb1()/strb2().
  localparam int unsigned PCOUT  = 1 << 13;
  localparam int unsigned MARIN  = 1 << 12;
  localparam int unsigned INCPC  = 1 << 11;
  localparam int unsigned ZIN    = 1 << 10;
  localparam int unsigned ZLOOUT = 1 << 9;
  localparam int unsigned ZHIOUT = 1 << 8;
  localparam int unsigned PCIN   = 1 << 7;
  localparam int unsigned READ   = 1 << 6;
  localparam int unsigned MDRIN  = 1 << 5;
  localparam int unsigned MDROUT = 1 << 4;
  localparam int unsigned IRIN   = 1 << 3;
  localparam int unsigned YIN    = 1 << 2;
  localparam int unsigned LOIN   = 1 << 1;
  localparam int unsigned HIIN   = 1 << 0;

  control_sequencer_if #(.DATA_WIDTH(32), .NUM_REGS(16)) bus1();
  control_sequencer_if #(.DATA_WIDTH(32), .NUM_REGS(8))  bus2();

  control_sequencer #(
    .DATA_WIDTH (32),
    .NUM_REGS   (16),
    .WAIT_MAX   (15)
  ) u_dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus1)
  );

  control_sequencer #(
    .DATA_WIDTH (32),
    .NUM_REGS   (8),
    .WAIT_MAX   (15)
  ) u_dut8 (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus2)
  );

  function automatic logic [13:0] strb1();
    return {bus1.PCout, bus1.MARin, bus1.IncPC, bus1.Zin, bus1.ZLOout,
            bus1.ZHIout, bus1.PCin, bus1.Read, bus1.MDRin, bus1.MDRout,
            bus1.IRin, bus1.Yin, bus1.LOin, bus1.HIin};
  endfunction

  function automatic logic [13:0] strb2();
    return {bus2.PCout, bus2.MARin, bus2.IncPC, bus2.Zin, bus2.ZLOout,
            bus2.ZHIout, bus2.PCin, bus2.Read, bus2.MDRin, bus2.MDRout,
            bus2.IRin, bus2.Yin, bus2.LOin, bus2.HIin};
  endfunction

  task automatic check(input string tag, input int unsigned obs,
                       input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and check one T-state cycle of bus1.
  task automatic cyc(input string tag, input int unsigned step,
                     input int unsigned strb, input int unsigned rout,
                     input int unsigned rin, input int unsigned alu,
                     input int unsigned done);
    @(negedge Clock);
    check({tag, ".step"}, 32'(bus1.Step),  step);
    check({tag, ".strb"}, 32'(strb1()),    strb);
    check({tag, ".rout"}, 32'(bus1.Rout),  rout);
    check({tag, ".rin"},  32'(bus1.Rin),   rin);
    check({tag, ".alu"},  32'(bus1.AluOp), alu);
    check({tag, ".done"}, 32'(bus1.Done),  done);
    check({tag, ".busy"}, 32'(bus1.Busy),  1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nread, nmdrin, npcin, nt1, ndone, gap;

    Clear = 1'b0;
    bus1.Run = 1'b0; bus1.IR = '0; bus1.Mem_ready = 1'b0;
    bus2.Run = 1'b0; bus2.IR = '0; bus2.Mem_ready = 1'b0;
    repeat (2) @(negedge Clock);

    // Reset state
    check("rst.step",   32'(bus1.Step), 0);
    check("rst.busy",   32'(bus1.Busy), 0);
    check("rst.fault",  32'(bus1.Fault), 0);
    check("rst.done",   32'(bus1.Done), 0);
    check("rst.icount", 32'(bus1.InstrCount), 0);
    check("rst.strb",   32'(strb1()), 0);
    check("rst.rout",   32'(bus1.Rout), 0);
    check("rst.alu",    32'(bus1.AluOp), 0);
    Clear = 1'b1;

    // Single SUB-class instruction (opcode 4, ra=1 rb=2 rc=3); Run drops
    // mid-instruction and must be ignored.
    bus1.IR = 32'h2091_8000; bus1.Mem_ready = 1'b1; bus1.Run = 1'b1;
    cyc("s1.t0", 1, PCOUT | MARIN | INCPC | ZIN, 0, 0, 0, 0);
    bus1.Run = 1'b0;
    cyc("s1.t1", 2, READ | MDRIN | ZLOOUT | PCIN, 0, 0, 0, 0);
    cyc("s1.t2", 3, MDROUT | IRIN, 0, 0, 0, 0);
    cyc("s1.t3", 4, YIN, 1 << 2, 0, 0, 0);
    cyc("s1.t4", 5, ZIN, 1 << 3, 0, 4, 0);
    cyc("s1.t5", 6, ZLOOUT, 0, 1 << 1, 0, 1);
    @(negedge Clock);
    check("s1.idle",   32'(bus1.Step), 0);
    check("s1.busy",   32'(bus1.Busy), 0);
    check("s1.done0",  32'(bus1.Done), 0);
    check("s1.icount", 32'(bus1.InstrCount), 1);

    // Memory stall: Mem_ready low for three T1 cycles
    bus1.Mem_ready = 1'b0; bus1.Run = 1'b1;
    nread = 0; nmdrin = 0; npcin = 0; nt1 = 0; ndone = 0;
    for (int unsigned i = 0; i < 20 && ndone == 0; i++) begin
      @(negedge Clock);
      bus1.Run = 1'b0;
      if (bus1.Step == 3'd2) begin
        nt1++;
        if (nt1 == 4) bus1.Mem_ready = 1'b1;
      end
      nread  += 32'(bus1.Read);
      nmdrin += 32'(bus1.MDRin);
      npcin  += 32'(bus1.PCin);
      ndone  += 32'(bus1.Done);
    end
    check("s2.t1cyc", nt1, 4);
    check("s2.read",  nread, 4);
    check("s2.mdrin", nmdrin, 4);
    check("s2.pcin",  npcin, 1);
    check("s2.done",  ndone, 1);
    @(negedge Clock);
    check("s2.icount", 32'(bus1.InstrCount), 2);

    // MUL (opcode 0x0E)
    bus1.IR = 32'h7091_8000; bus1.Mem_ready = 1'b1; bus1.Run = 1'b1;
    cyc("s4.t0", 1, PCOUT | MARIN | INCPC | ZIN, 0, 0, 0, 0);
    bus1.Run = 1'b0;
    cyc("s4.t1", 2, READ | MDRIN | ZLOOUT | PCIN, 0, 0, 0, 0);
    cyc("s4.t2", 3, MDROUT | IRIN, 0, 0, 0, 0);
`ifdef CTRL_MULDIV_EN
    cyc("s4.t3", 4, YIN, 1 << 2, 0, 0, 0);
    cyc("s4.t4", 5, ZIN, 1 << 3, 0, 14, 0);
    cyc("s4.t5", 6, ZLOOUT | LOIN, 0, 0, 0, 0);
    cyc("s4.t6", 7, ZHIOUT | HIIN, 0, 0, 0, 1);
    @(negedge Clock);
    check("s4.icount", 32'(bus1.InstrCount), 3);
    check("s4.fault",  32'(bus1.Fault), 0);
`else
    cyc("s4.t3", 4, 0, 0, 0, 0, 0);
    @(negedge Clock);
    check("s4.fault", 32'(bus1.Fault), 1);
    check("s4.busy",  32'(bus1.Busy), 0);
    check("s4.step",  32'(bus1.Step), 0);
    check("s4.strb",  32'(strb1()), 0);
    check("s4.icount", 32'(bus1.InstrCount), 2);
`endif
    Clear = 1'b0;
    @(negedge Clock);
    check("s4.clr_icount", 32'(bus1.InstrCount), 0);
    check("s4.clr_fault",  32'(bus1.Fault), 0);
    Clear = 1'b1;

    // Back-to-back with Run held, then Clear in the middle of T4
    bus1.IR = 32'h2091_8000; bus1.Mem_ready = 1'b1; bus1.Run = 1'b1;
    gap = 0; ndone = 0;
    for (int unsigned i = 0; i < 23; i++) begin
      @(negedge Clock);
      if (32'(bus1.Step) != (i % 6) + 1) gap++;
      ndone += 32'(bus1.Done);
    end
    check("s5.nogap",  gap, 0);
    check("s5.done",   ndone, 3);
    check("s5.icount", 32'(bus1.InstrCount), 3);
    check("s5.t4alu",  32'(bus1.AluOp), 4);
    Clear = 1'b0;
    #1;
    check("s5.clr_step",   32'(bus1.Step), 0);
    check("s5.clr_icount", 32'(bus1.InstrCount), 0);
    check("s5.clr_busy",   32'(bus1.Busy), 0);
    check("s5.clr_strb",   32'(strb1()), 0);
    bus1.Run = 1'b0;
    @(negedge Clock);
    Clear = 1'b1;

    // Memory timeout: Mem_ready never arrives
    bus1.Mem_ready = 1'b0; bus1.Run = 1'b1;
    nt1 = 0;
    for (int unsigned i = 0; i < 40 && !bus1.Fault; i++) begin
      @(negedge Clock);
      if (bus1.Step == 3'd2) nt1++;
    end
    check("s3.t1cyc", nt1, 15);
    check("s3.fault", 32'(bus1.Fault), 1);
    check("s3.busy",  32'(bus1.Busy), 0);
    check("s3.strb",  32'(strb1()), 0);
    check("s3.step",  32'(bus1.Step), 0);
    bus1.Mem_ready = 1'b1;
    repeat (5) @(negedge Clock);
    check("s3.hold_fault", 32'(bus1.Fault), 1);
    check("s3.hold_strb",  32'(strb1()), 0);
    Clear = 1'b0;
    bus1.Run = 1'b0;
    @(negedge Clock);
    check("s3.clr_fault", 32'(bus1.Fault), 0);
    check("s3.clr_step",  32'(bus1.Step), 0);
    Clear = 1'b1;

    // NUM_REGS=8 instance, rb=9 is out of range
    bus2.IR = (32'd4 << 27) | (32'd1 << 23) | (32'd9 << 19) | (32'd3 << 15);
    bus2.Mem_ready = 1'b1; bus2.Run = 1'b1;
    @(negedge Clock);
    bus2.Run = 1'b0;
    repeat (3) @(negedge Clock);
    check("s6.t3step", 32'(bus2.Step), 4);
    check("s6.t3strb", 32'(strb2()), 0);
    check("s6.t3rout", 32'(bus2.Rout), 0);
    @(negedge Clock);
    check("s6.fault",  32'(bus2.Fault), 1);
    check("s6.step",   32'(bus2.Step), 0);
    check("s6.busy",   32'(bus2.Busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath word width; legal range is 32 or more.
REQ-002 SHALL have parameter NUM_REGS, default 16, number of general registers; legal range is 2 to 16.
REQ-003 SHALL have parameter WAIT_MAX, default 15, maximum number of memory-wait cycles in T1.
REQ-004 SHALL have ports Clock in 1 (sole clock) and Clear in 1 (reset); one clock, reset asynchronous and active-low.
REQ-005 SHALL have port Run in 1: start/continue request.
REQ-006 SHALL have port IR in DATA_WIDTH: current instruction register contents.
REQ-007 SHALL have port Mem_ready in 1: memory data valid for the MDR.
REQ-008 SHALL have outputs PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin, Yin, LOin and HIin, each out 1, as datapath strobes.
REQ-009 SHALL have outputs Rout and Rin, each out NUM_REGS, one-hot register bus-drive and register-load selects.
REQ-010 SHALL have output AluOp out 5: operation code for the ALU.
REQ-011 SHALL have outputs Busy, Done and Fault, each out 1, plus Step out 3 (encoded current state).
REQ-012 SHALL have output InstrCount out 16: number of completed instructions.

Function
REQ-013 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6 and FAULT, advancing one state per Clock rising edge unless stalled.
REQ-014 SHALL decode IR fields as follows: opcode=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
REQ-015 SHALL generate strobes as a pure function of the registered state and the latched fields, with no combinational path from Run or Mem_ready to any strobe.
REQ-016 SHALL move from IDLE to T0 on the next edge after Run=1 is sampled.
REQ-017 SHALL assert PCout, MARin, IncPC and Zin in T0.
REQ-018 SHALL assert Read and MDRin for every cycle of T1, and ZLOout and PCin only in the first cycle of T1, so that the PC is written once per instruction.
REQ-019 SHALL stall in T1 while Mem_ready=0, and leave T1 on the edge where Mem_ready=1.
REQ-020 SHALL enter FAULT if the stall counter reaches WAIT_MAX with Mem_ready still 0.
REQ-021 SHALL assert MDRout and IRin in T2.
REQ-022 SHALL latch opcode, ra, rb and rc from IR on the edge leaving T2.
REQ-023 SHALL assert Rout[rb] and Yin in T3.
REQ-024 SHALL assert Rout[rc], Zin and AluOp=opcode in T4, with AluOp=0 in every other state.
REQ-025 SHALL assert ZLOout and Rin[ra] in T5, except for mul/div, where it SHALL assert ZLOout and LOin.
REQ-026 SHALL assert ZHIout and HIin in T6, reached only for mul/div.
REQ-027 SHALL enter FAULT from T3 on an illegal opcode, or when ra, rb or rc is greater than or equal to NUM_REGS.
REQ-028 SHALL assert no strobe in T3 when the transition to FAULT occurs.
REQ-029 SHALL, at the end of an instruction (T5, or T6 for mul/div), pulse Done for one cycle and increment InstrCount.
REQ-030 SHALL wrap InstrCount from 0xFFFF to 0x0000.
REQ-031 SHALL, at the end of an instruction, go to T0 if Run=1 and otherwise to IDLE.
REQ-032 SHALL ignore Run deasserting mid-instruction; the current instruction completes.
REQ-033 SHALL assert Busy whenever the state is not IDLE or FAULT.
REQ-034 SHALL hold FAULT, with Fault=1 and all strobes 0, until Clear.

Reset
REQ-035 SHALL, while Clear=0, force state IDLE, every strobe, Rout, Rin and AluOp to 0, Busy, Done and Fault to 0, Step to 0, InstrCount to 0, the stall counter to 0 and the latched fields to 0.
REQ-036 SHALL, on reset mid-instruction, abandon the instruction without incrementing InstrCount.

Configuration
REQ-037 SHALL support macro CTRL_MULDIV_EN; when defined, opcodes MUL (0x0E) and DIV (0x0F) take the T5 LOin step followed by T6.
REQ-038 SHALL, when CTRL_MULDIV_EN is undefined, treat MUL and DIV as illegal opcodes (FAULT), and T6 SHALL be unreachable.

Structure
REQ-039 SHALL take the state encoding, the opcode constants, the IR field bit positions and the legal-opcode list from shared package ctrl_pkg.
REQ-040 SHALL place the field decode and legality check in sub-module ctrl_decode; the state machine, stall counter and instruction counter stay in the top level.

Verification
REQ-041 SHALL check: Clear=0 then released, Run=1, Mem_ready=1, IR=0x20918000 -> T0 to T5 in 6 cycles; Rout[2] asserted in T3, Rout[3] with AluOp=4 in T4, Rin[1] in T5; Done pulses once; InstrCount=1.
REQ-042 SHALL check: Mem_ready held 0 for 3 cycles in T1 -> Read and MDRin high for 4 cycles; PCin high for exactly 1 cycle.
REQ-043 SHALL check: Mem_ready held 0 for 15 cycles -> Fault=1 and Busy=0; Fault stays set until Clear.
REQ-044 SHALL check: IR=0x70918000 (MUL) -> with CTRL_MULDIV_EN, LOin in T5 and HIin in T6, Done after 7 cycles; without the macro -> FAULT after T3.
REQ-045 SHALL check: Run held high for 3 instructions -> back-to-back T0 with no IDLE gap; InstrCount=3; Clear asserted mid-T4 -> IDLE with InstrCount=0.
REQ-046 SHALL check: NUM_REGS=8 with IR rb field 9 -> FAULT from T3 with no Rout asserted.
